dispatch: RTL

- Dispatch stage between rename and issue.
- Buffers one renamed group of up to PIPE_WIDTH instructions.
- Routes each instruction to a reservation station by class: ALU RS (0), load queue (1) or store queue (2).
- Writes instructions through the issue stage's per-RS write lanes, strictly in program order, using the issue stage's per-lane ready bits for back-pressure.

---
 rtl/riscv_isa_pkg.sv | 16 +
 rtl/uarch_pkg.sv | 38 +++
 rtl/dispatch_router.sv | 55 +++++
 rtl/dispatch.sv | 64 ++++++
 4 files changed

// File: rtl/riscv_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_isa_pkg
//  Description : RISC-V major opcode constants shared by the core.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_isa_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage
`default_nettype wire

// File: rtl/uarch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uarch_pkg
//  Description : Microarchitecture parameters, renamed instruction format and
//                reservation-station class decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package uarch_pkg;

    import riscv_isa_pkg::*;

    localparam int PIPE_WIDTH = 2;
    localparam int NUM_RS     = 3;
    localparam int RS_IDX_W   = 2;

    localparam logic [RS_IDX_W-1:0] RS_ALU = 2'd0;
    localparam logic [RS_IDX_W-1:0] RS_LD  = 2'd1;
    localparam logic [RS_IDX_W-1:0] RS_ST  = 2'd2;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [5:0]  prd;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic [31:0] imm;
    } instruction_t;

    // Anything that is not a memory op (including illegal opcodes) goes to the ALU RS.
    function automatic logic [RS_IDX_W-1:0] rs_sel(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD:  rs_sel = RS_LD;
            OPC_STORE: rs_sel = RS_ST;
            default:   rs_sel = RS_ALU;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_router.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_router
//  Description : Combinational in-order lane allocator. Maps the held group
//                onto per-RS write lanes, stopping at the first slot that
//                cannot be placed.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_router
    import uarch_pkg::*;
(
    input  instruction_t [PIPE_WIDTH-1:0]               hold_pkt,
    input  logic         [PIPE_WIDTH-1:0]               hold_val,
    input  logic         [NUM_RS-1:0][PIPE_WIDTH-1:0]   rs_rdys,
    output logic         [NUM_RS-1:0][PIPE_WIDTH-1:0]   rs_wes,
    output instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0]   rs_issue_ports,
    output logic         [PIPE_WIDTH-1:0]               dispatched
);

    localparam int c_LANE_W = (PIPE_WIDTH > 1) ? $clog2(PIPE_WIDTH) : 1;

    logic                 w_blocked;
    logic [RS_IDX_W-1:0]  w_r;
    logic [c_LANE_W-1:0]  w_k;
    logic [c_LANE_W-1:0]  w_cnt [NUM_RS];

    // Walk slots oldest-first; each slot takes the next free lane of its RS, first failure blocks the rest.
    always_comb begin
        rs_wes         = '0;
        rs_issue_ports = '0;
        dispatched     = '0;
        w_blocked      = 1'b0;
        w_r            = '0;
        w_k            = '0;
        for (int r = 0; r < NUM_RS; r++) begin
            w_cnt[r] = '0;
        end
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (hold_val[i] && !w_blocked) begin
                w_r = rs_sel(hold_pkt[i].opcode);
                w_k = w_cnt[w_r];
                if (rs_rdys[w_r][w_k]) begin
                    rs_wes[w_r][w_k]         = 1'b1;
                    rs_issue_ports[w_r][w_k] = hold_pkt[i];
                    dispatched[i]            = 1'b1;
                    w_cnt[w_r]               = w_cnt[w_r] + 1'b1;
                end else begin
                    w_blocked = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch
//  Description : Dispatch stage between rename and issue. Holds one renamed
//                group and drains it in program order into the ALU RS, load
//                queue and store queue write lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch
    import uarch_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  instruction_t [PIPE_WIDTH-1:0]               rename_pkts,
    input  logic         [PIPE_WIDTH-1:0]               rename_vals,
    output logic                                        dispatch_rdy,
    input  logic         [NUM_RS-1:0][PIPE_WIDTH-1:0]   rs_rdys,
    output logic         [NUM_RS-1:0][PIPE_WIDTH-1:0]   rs_wes,
    output instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0]   rs_issue_ports
);

    instruction_t [PIPE_WIDTH-1:0]              r_hold_pkt;
    logic         [PIPE_WIDTH-1:0]              r_hold_val;

    logic         [NUM_RS-1:0][PIPE_WIDTH-1:0]  w_wes;
    instruction_t [NUM_RS-1:0][PIPE_WIDTH-1:0]  w_ports;
    logic         [PIPE_WIDTH-1:0]              w_disp;
    logic                                       w_drained;

    dispatch_router u_router (
        .hold_pkt       (r_hold_pkt),
        .hold_val       (r_hold_val),
        .rs_rdys        (rs_rdys),
        .rs_wes         (w_wes),
        .rs_issue_ports (w_ports),
        .dispatched     (w_disp)
    );

    // Handshake: accept a new group once every held slot leaves this cycle; flush suppresses all writes.
    always_comb begin
        w_drained      = ((r_hold_val & ~w_disp) == '0);
        dispatch_rdy   = w_drained | flush;
        rs_wes         = flush ? '0 : w_wes;
        rs_issue_ports = flush ? '0 : w_ports;
    end

    // Holding register: reload when drained, otherwise retire dispatched slots in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_val <= '0;
            r_hold_pkt <= '0;
        end else if (flush) begin
            r_hold_val <= '0;
        end else if (w_drained) begin
            r_hold_val <= rename_vals;
            r_hold_pkt <= rename_pkts;
        end else begin
            r_hold_val <= r_hold_val & ~w_disp;
        end
    end

endmodule
`default_nettype wire
